// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin bit-select arbiter.
// Imported by the interface, the mux datapath and the arbiter top.
package mux_arb_pkg;

    localparam int N_REQ         = 16;
    localparam int SEL_W         = 4;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_16to1_arbiter_if.sv
// Bus bundle between the 16 bit-serial sources, the arbiter and the shared output lane.
// The slave modport is the arbiter's view; the master modport drives requests and ready.
interface mux_16to1_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] in_data;
    logic             out_ready;
    logic             out_valid;
    logic             out_data;
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] gnt;
    logic             xfer;

    modport slave (
        input  req,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output sel,
        output gnt,
        output xfer
    );

    modport master (
        output req,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  sel,
        input  gnt,
        input  xfer
    );

endinterface

// File: rtl/mux_16to1.sv
// Plain 16:1 bit-select datapath; the arbiter owns its select.
module mux_16to1
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_data,
    input  logic [SEL_W-1:0] sel,
    output logic             out_data
);

    assign out_data = in_data[sel];

endmodule

// File: rtl/mux_16to1_arbiter.sv
// Round-robin arbiter sharing the 16:1 bit mux among 16 requesters with bounded bursts
// and a valid/ready handoff to a single downstream consumer.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no owner, gnt = 0, sel holds last owner
//   GRANT | owner = sel, gnt[sel] = 1, out_valid = req[sel]
module mux_16to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_16to1_arbiter_if.slave    bus
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic             owner_req;
    logic             out_valid;
    logic             xfer;
    logic             rel;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] pick_base;

    localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(MAX_BURST - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    // First requester at or after ptr, wrapping mod 16. Returns {found, index}.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] ptr);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    mux_16to1 u_mux (
        .in_data  (bus.in_data),
        .sel      (sel_q),
        .out_data (bus.out_data)
    );

    assign owner_req = bus.req[sel_q];
    assign out_valid = (state_q == GRANT) && owner_req;
    assign xfer      = out_valid && bus.out_ready;
    assign rel       = (state_q == GRANT) &&
                       (!owner_req || (xfer && (cnt_q == LAST_BEAT)));

    // On release the pointer moves past the old owner before the re-pick.
    assign pick_base = (state_q == GRANT) ? sel_q + 1'b1 : ptr_q;
    assign {pick_found, pick_idx} = rr_pick(bus.req, pick_base);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = ONE_HOT0 << pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d = pick_base;
                    cnt_d = '0;
                    if (pick_found) begin
                        sel_d = pick_idx;
                        gnt_d = ONE_HOT0 << pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.out_valid = out_valid;
    assign bus.xfer      = xfer;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;

endmodule

// File: doc/mux_16to1_arbiter.md
# mux_16to1_arbiter

Round-robin arbiter that shares the 16:1 bit-select datapath among 16 requesters. It owns the 4-bit select of an internal `mux_16to1` instance and grants one requester at a time for a bounded burst. It forwards the selected bit to a single downstream consumer through a valid/ready handshake. It sits between the 16 bit-serial sources and the one shared output lane.

## Interface

Parameters:
- `N_REQ`, 16: number of requesters. Fixed at 16 to match the mux width.
- `SEL_W`, 4: select width, log2(`N_REQ`).
- `MAX_BURST`, 4: maximum accepted transfers per grant. Legal range 1..15.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  16: per-requester request level. Held high while the requester has data.
- `in_data`  in  16: per-requester data bit. `in_data[i]` is valid when `req[i]` is high.
- `out_ready`  in  1: downstream accepts `out_data` this cycle.
- `out_valid`  out  1: `out_data` carries a granted requester's bit.
- `out_data`  out  1: `in_data[sel]` via the internal mux.
- `sel`  out  4: registered mux select, equal to the current owner index.
- `gnt`  out  16: registered one-hot grant, all-zero when no owner.
- `xfer`  out  1: combinational pulse, `out_valid & out_ready`. Tells the owner its bit was consumed.

## Operation

- States:
  - IDLE: no owner, `gnt`=0.
  - GRANT: owner = `sel`, `gnt[sel]`=1.
- Registers: `state`, `sel`, `ptr` (4-bit rotating priority pointer), `cnt` (4-bit burst count).
- Pick function: first index i scanning `ptr`, `ptr`+1, …, `ptr`+15 (mod 16) with `req[i]`=1.
- IDLE:
  - If `req`≠0: next `sel`=pick, `gnt`=one-hot(pick), `cnt`=0, go to GRANT.
  - Else stay in IDLE.
- GRANT:
  - `out_valid` = `req[sel]`, combinational.
  - Each `xfer`: `cnt` += 1.
- Release condition in GRANT:
  - `req[sel]`=0, or
  - `xfer` with `cnt`==`MAX_BURST`-1.
- On release:
  - `ptr` = `sel`+1 (mod 16, 15 wraps to 0).
  - Re-pick in the same cycle using the updated `ptr`.
  - If a requester is found: stay in GRANT with new `sel`/`gnt`, `cnt`=0. No idle bubble.
  - Otherwise go to IDLE with `gnt`=0. `sel` holds its last value.
- A burst-limited owner still requesting is lowest priority after rotation. If it is the sole requester, it is re-granted immediately.
- `out_ready` low: `cnt` and ownership hold. Release is due to `req` drop only.
- `req` changes on non-owners never affect the current grant.
- Reset values: `state`=IDLE, `sel`=0, `ptr`=0, `cnt`=0, `gnt`=0, `out_valid`=0, `xfer`=0. `out_data`=`in_data[0]` (don't-care while `out_valid`=0).
- Reset asserted mid-burst: the transfer in that cycle is not counted. All registers take reset values at that edge.

## Timing

- Grant latency: `req[i]` high at edge k with IDLE → `gnt[i]`/`sel`=i after edge k. `out_valid` is possible in cycle k+1.
- Handover latency: zero bubble. The new owner's `out_valid` is possible the cycle after the release edge.
- Throughput: 1 bit/cycle while `out_ready` is held high.
- `out_data`, `out_valid` and `xfer` are combinational from registered `sel` and the inputs. There is no combinational path from `out_ready` to `sel`/`gnt`.
- `out_valid` may drop without a transfer if the owner withdraws `req`. The consumer must not assume a sticky valid.

## Structure

- Shared package `mux_arb_pkg`: state encoding (IDLE=0, GRANT=1), `N_REQ`, `SEL_W`, default `MAX_BURST`.
- Sub-module: the existing `mux_16to1`, instanced as the data path (`out_data`, `in_data`, `sel`).
- Round-robin pick is a local function, not a separate module.

## Test plan

- Reset: `rst_n`=0 for 2 cycles with `req`=16'hFFFF → `gnt`=0, `sel`=0, `out_valid`=0. Release reset → `gnt`=16'h0001 one cycle later.
- Single requester: `req`=16'h0020, `in_data[5]` toggling, `out_ready`=1 → `sel`=5. Bursts of 4 back-to-back with no gap, and `out_data` tracks `in_data[5]`.
- Rotation: `req`=16'h8101, `out_ready`=1, `MAX_BURST`=4 → owners 0,8,15,0,… each for exactly 4 `xfer`. 15→0 wrap is checked.
- Backpressure: owner 3, `out_ready` low for 5 cycles mid-burst → `cnt` holds, `gnt` unchanged. Exactly 4 `xfer` total.
- Early drop: owner 2 drops `req` after 1 transfer while `req[9]`=1 → `gnt`=16'h0200 next cycle, `ptr`=3.
- Reset mid-burst: `rst_n`=0 during owner 7's second transfer → next cycle IDLE, `ptr`=0, `gnt`=0. Re-arbitration starts from index 0.
